// File: rtl/lfsr_rng_pkg.sv
// Shared constants and the per-channel seed derivation for the LFSR random-word bank.
package lfsr_rng_pkg;

    localparam logic [31:0] CH_SALT       = 32'h9E37_79B9;
    localparam logic [31:0] DEF_TAP_MASK  = 32'h4040_2020;
    localparam logic [31:0] DEF_SEED_BASE = 32'h6BF2_7D49;

    // Channel i seed for an LFSR of width w (w <= 64); all-ones would lock the register.
    function automatic logic [63:0] derive_seed(input logic [63:0] s, input int unsigned i,
                                                input int unsigned w);
        logic [63:0] mask;
        logic [63:0] seed;
        mask = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        seed = (s ^ (64'(i) * 64'(CH_SALT))) & mask;
        if (seed == mask) begin
            seed = mask ^ 64'd1;
        end
        return seed;
    endfunction

endpackage

// File: rtl/lfsr_chan.sv
// One Fibonacci LFSR channel with XNOR feedback, reseed and all-ones lock-up recovery.
module lfsr_chan
    import lfsr_rng_pkg::*;
#(
    parameter int                 LFSR_W   = 32,
    parameter logic [LFSR_W-1:0]  TAP_MASK = DEF_TAP_MASK
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              step,
    input  logic              load,
    input  logic [LFSR_W-1:0] seed,
    input  logic [LFSR_W-1:0] reset_seed,
    output logic              fb,
    output logic              lock
);

    logic [LFSR_W-1:0] state;
    logic              all_ones;

    assign all_ones = &state;
    assign fb       = ~^(state & TAP_MASK);
    assign lock     = step & all_ones;

    // The lock-up state still emits fb (=1); recovery reloads the channel seed instead of shifting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= reset_seed;
        end else if (load) begin
            state <= seed;
        end else if (step) begin
            state <= all_ones ? seed : {state[LFSR_W-2:0], fb};
        end
    end

endmodule

// File: rtl/lfsr_rng_bank.sv
// Bank of N_CH LFSR channels packed into OUT_W-bit words behind a valid/ready handshake.
module lfsr_rng_bank
    import lfsr_rng_pkg::*;
#(
    parameter int                 N_CH      = 8,
    parameter int                 LFSR_W    = 32,
    parameter int                 OUT_W     = 8,
    parameter logic [LFSR_W-1:0]  TAP_MASK  = DEF_TAP_MASK,
    parameter logic [LFSR_W-1:0]  SEED_BASE = DEF_SEED_BASE
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              seed_load,
    input  logic [LFSR_W-1:0] seed_in,
    output logic              rnd_valid,
    input  logic              rnd_ready,
    output logic [OUT_W-1:0]  rnd_data,
    output logic [15:0]       lock_cnt
);

    localparam int K     = OUT_W / N_CH;
    localparam int CNT_W = (K > 1) ? $clog2(K) : 1;

    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[16] ? 16'hFFFF : sum[15:0];
    endfunction

    logic [N_CH-1:0]   step_bits;
    logic [N_CH-1:0]   lock;
    logic [LFSR_W-1:0] s_reg;
    logic [LFSR_W-1:0] seed_src;
    logic [OUT_W-1:0]  word_next;
    logic [15:0]       lock_sum;
    logic              last;
    logic              step;
    logic              word_done;

    // Stall only when the accumulator is full and the pending word has not been taken.
    assign step      = en & ~seed_load & (~last | ~rnd_valid | rnd_ready);
    assign word_done = step & last;
    assign seed_src  = seed_load ? seed_in : s_reg;

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
        localparam logic [LFSR_W-1:0] RST_SEED = LFSR_W'(derive_seed(64'(SEED_BASE), gi, LFSR_W));
        logic [LFSR_W-1:0] seed_ch;

        assign seed_ch = LFSR_W'(derive_seed(64'(seed_src), gi, LFSR_W));

        lfsr_chan #(
            .LFSR_W   (LFSR_W),
            .TAP_MASK (TAP_MASK)
        ) u_chan (
            .clk        (clk),
            .rst_n      (rst_n),
            .step       (step),
            .load       (seed_load),
            .seed       (seed_ch),
            .reset_seed (RST_SEED),
            .fb         (step_bits[gi]),
            .lock       (lock[gi])
        );
    end

    if (K > 1) begin : g_acc
        logic [OUT_W-N_CH-1:0] acc;
        logic [CNT_W-1:0]      acc_cnt;

        assign last      = (acc_cnt == CNT_W'(K - 1));
        assign word_next = {acc, step_bits};

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                acc     <= '0;
                acc_cnt <= '0;
            end else if (seed_load) begin
                acc     <= '0;
                acc_cnt <= '0;
            end else if (step) begin
                if (last) begin
                    acc_cnt <= '0;
                end else begin
                    acc     <= word_next[OUT_W-N_CH-1:0];
                    acc_cnt <= acc_cnt + CNT_W'(1);
                end
            end
        end
    end else begin : g_noacc
        assign last      = 1'b1;
        assign word_next = step_bits;
    end

    always_comb begin
        lock_sum = '0;
        for (int i = 0; i < N_CH; i++) begin
            lock_sum = lock_sum + 16'(lock[i]);
        end
    end

    // A completing word wins over the handshake so back-to-back words keep valid high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_reg     <= SEED_BASE;
            rnd_valid <= 1'b0;
            rnd_data  <= '0;
            lock_cnt  <= '0;
        end else begin
            if (seed_load) begin
                s_reg <= seed_in;
            end
            if (word_done) begin
                rnd_data  <= word_next;
                rnd_valid <= 1'b1;
            end else if (rnd_valid && rnd_ready) begin
                rnd_valid <= 1'b0;
            end
            lock_cnt <= sat_add16(lock_cnt, lock_sum);
        end
    end

endmodule

// File: tb/tb_lfsr_rng_bank.sv
// Scoreboard bench for lfsr_rng_bank: one K=1 (OUT_W=8) and one K=4 (OUT_W=32) instance side by side.
`timescale 1ns/1ps
module tb_lfsr_rng_bank;

    localparam logic [31:0] TAPS  = 32'h4040_2020;
    localparam logic [31:0] SEED0 = 32'h6BF2_7D49;
    localparam logic [31:0] SALT  = 32'h9E37_79B9;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        seed_load;
    logic        rdy;
    logic [31:0] seed_in;
    logic        v8, v32;
    logic [7:0]  d8;
    logic [31:0] d32;
    logic [15:0] lc8, lc32;

    always #5 clk = ~clk;

    lfsr_rng_bank #(.N_CH(8), .LFSR_W(32), .OUT_W(8)) u_dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .seed_load (seed_load),
        .seed_in   (seed_in),
        .rnd_valid (v8),
        .rnd_ready (rdy),
        .rnd_data  (d8),
        .lock_cnt  (lc8)
    );

    lfsr_rng_bank #(.N_CH(8), .LFSR_W(32), .OUT_W(32)) u_dut32 (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .seed_load (seed_load),
        .seed_in   (seed_in),
        .rnd_valid (v32),
        .rnd_ready (rdy),
        .rnd_data  (d32),
        .lock_cnt  (lc32)
    );

    // Reference model state, index 0 = K=1 instance, index 1 = K=4 instance.
    logic [31:0] m_st [2][8];
    logic [31:0] m_s [2];
    logic [31:0] m_acc [2];
    int          m_cnt [2];
    bit          m_valid [2];
    int          m_lock [2];
    logic [31:0] q0 [$];
    logic [31:0] q1 [$];
    int          n_tests = 0;
    int          n_fail = 0;

    function automatic logic [31:0] tb_seed(input logic [31:0] s, input int i);
        logic [31:0] r;
        r = s ^ (SALT * 32'(i));
        if (r == 32'hFFFF_FFFF) r = 32'hFFFF_FFFE;
        return r;
    endfunction

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 8; i++) m_st[d][i] = tb_seed(SEED0, i);
            m_s[d]     = SEED0;
            m_acc[d]   = '0;
            m_cnt[d]   = 0;
            m_valid[d] = 1'b0;
            m_lock[d]  = 0;
        end
        q0.delete();
        q1.delete();
    endtask

    task automatic model_update(input int d);
        int          k;
        logic [7:0]  bits;
        logic [31:0] word;
        bit          last, stp;
        k    = (d == 0) ? 1 : 4;
        last = (m_cnt[d] == k - 1);
        stp  = en && !seed_load && (!last || !m_valid[d] || rdy);
        for (int i = 0; i < 8; i++) bits[i] = ~^(m_st[d][i] & TAPS);
        if (m_valid[d] && rdy) m_valid[d] = 1'b0;
        if (seed_load) begin
            for (int i = 0; i < 8; i++) m_st[d][i] = tb_seed(seed_in, i);
            m_s[d]   = seed_in;
            m_acc[d] = '0;
            m_cnt[d] = 0;
        end else if (stp) begin
            for (int i = 0; i < 8; i++) begin
                if (m_st[d][i] == 32'hFFFF_FFFF) begin
                    m_st[d][i] = tb_seed(m_s[d], i);
                    if (m_lock[d] < 65535) m_lock[d]++;
                end else begin
                    m_st[d][i] = {m_st[d][i][30:0], bits[i]};
                end
            end
            word = {m_acc[d][23:0], bits};
            if (last) begin
                if (d == 0) q0.push_back({24'h0, bits});
                else        q1.push_back(word);
                m_valid[d] = 1'b1;
                m_cnt[d]   = 0;
            end else begin
                m_acc[d] = word;
                m_cnt[d]++;
            end
        end
    endtask

    task automatic check_out(input int d);
        logic [31:0] vv, dv, lv, exp;
        vv  = (d == 0) ? 32'(v8)  : 32'(v32);
        dv  = (d == 0) ? 32'(d8)  : d32;
        lv  = (d == 0) ? 32'(lc8) : 32'(lc32);
        exp = 32'hDEAD_BEEF;
        chk_eq($sformatf("valid_k%0d", d), vv, 32'(m_valid[d]));
        if (m_valid[d]) begin
            if (d == 0 && q0.size() > 0) exp = rdy ? q0.pop_front() : q0[0];
            if (d == 1 && q1.size() > 0) exp = rdy ? q1.pop_front() : q1[0];
            chk_eq($sformatf("data_k%0d", d), dv, exp);
        end
        chk_eq($sformatf("lock_k%0d", d), lv, 32'(m_lock[d]));
    endtask

    task automatic cycle();
        @(negedge clk);
        for (int d = 0; d < 2; d++) check_out(d);
        if (!rst_n) model_reset();
        else for (int d = 0; d < 2; d++) model_update(d);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int          words;
        int          lb8, lb32;
        logic [31:0] t1_word;
        rst_n = 1'b0; en = 1'b0; seed_load = 1'b0; rdy = 1'b1; seed_in = '0;
        model_reset();
        repeat (3) cycle();
        chk_eq("rst_v8", 32'(v8), 0);
        chk_eq("rst_d8", 32'(d8), 0);
        chk_eq("rst_lc8", 32'(lc8), 0);
        chk_eq("rst_v32", 32'(v32), 0);
        chk_eq("rst_d32", d32, 0);
        chk_eq("rst_lc32", 32'(lc32), 0);
        rst_n = 1'b1;

        // Scenario 1: free run from reset
        en = 1'b1;
        chk_eq("t1_pre_v8", 32'(v8), 0);
        cycle();
        t1_word = (q0.size() > 0) ? q0[0] : 32'hDEAD_BEEF;
        chk_eq("t1_first_v8", 32'(v8), 1);
        chk_eq("t1_first_v32_low", 32'(v32), 0);
        repeat (3) cycle();
        chk_eq("t1_first_v32", 32'(v32), 1);
        repeat (12) cycle();

        // Scenario 2: reseed with zero
        seed_in = '0; seed_load = 1'b1; cycle(); seed_load = 1'b0;
        cycle();
        chk_eq("t2_ch0_fb", 32'(d8[0]), 1);
        repeat (6) cycle();

        // Scenario 3: all-ones seed substitution, then forced lock-up
        lb8 = m_lock[0]; lb32 = m_lock[1];
        seed_in = 32'hFFFF_FFFF; seed_load = 1'b1; cycle(); seed_load = 1'b0;
        repeat (3) cycle();
        chk_eq("t3_no_lock", 32'(lc8), 32'(lb8));
        lb8 = m_lock[0]; lb32 = m_lock[1];
        seed_in = 32'h7FFF_FFFF; seed_load = 1'b1; cycle(); seed_load = 1'b0;
        cycle(); cycle();
        chk_eq("t3_lock_k1", 32'(lc8), 32'(lb8 + 1));
        chk_eq("t3_lock_k4", 32'(lc32), 32'(lb32 + 1));
        cycle();

        // Scenario 4: backpressure on the K=4 instance
        en = 1'b0; rdy = 1'b1; repeat (2) cycle();
        seed_in = 32'h1234_5678; seed_load = 1'b1; cycle(); seed_load = 1'b0;
        rdy = 1'b0; en = 1'b1;
        repeat (3) cycle();
        chk_eq("t4_not_yet", 32'(v32), 0);
        cycle();
        chk_eq("t4_valid", 32'(v32), 1);
        repeat (10) cycle();
        chk_eq("t4_held", 32'(v32), 1);
        rdy = 1'b1; cycle();
        chk_eq("t4_reload", 32'(v32), 1);
        rdy = 1'b0; repeat (3) cycle();

        // Scenario 5: en toggling
        en = 1'b0; rdy = 1'b1; repeat (2) cycle();
        seed_in = 32'hCAFE_F00D; seed_load = 1'b1; cycle(); seed_load = 1'b0;
        words = 0;
        for (int c = 0; c < 34; c++) begin
            en = (c < 32 && c % 2 == 0);
            cycle();
            if (v32) words++;
        end
        chk_eq("t5_words", 32'(words), 4);

        // Scenario 6: reset mid-accumulation with a pending word
        en = 1'b0; rdy = 1'b1; repeat (2) cycle();
        seed_in = 32'h0BAD_F00D; seed_load = 1'b1; cycle(); seed_load = 1'b0;
        rdy = 1'b0; en = 1'b1;
        repeat (6) cycle();
        chk_eq("t6_pre_valid", 32'(v32), 1);
        rst_n = 1'b0;
        #1;
        chk_eq("t6_rst_v32", 32'(v32), 0);
        chk_eq("t6_rst_d32", d32, 0);
        chk_eq("t6_rst_v8", 32'(v8), 0);
        chk_eq("t6_rst_d8", 32'(d8), 0);
        model_reset();
        repeat (2) cycle();
        rst_n = 1'b1; rdy = 1'b1; en = 1'b1;
        cycle();
        chk_eq("t6_restart_v8", 32'(v8), 1);
        chk_eq("t6_same_as_t1", 32'(d8), t1_word);
        repeat (3) cycle();
        chk_eq("t6_restart_v32", 32'(v32), 1);
        repeat (12) cycle();

        en = 1'b0; rdy = 1'b1; repeat (2) cycle();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
